// File: rtl/inst_fetch_cache_pkg.sv
// Shared types and state encoding for the instruction fetch front end.
package inst_fetch_cache_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    LOOKUP    = 2'b00,
    MISS_REQ  = 2'b01,
    MISS_WAIT = 2'b10
  } if_state_e;
endpackage

// File: rtl/inst_fetch_cache_if.sv
// Fetch-unit bus: ROB redirect, memory-controller IF port and decoder port.
interface inst_fetch_cache_if;
  import inst_fetch_cache_pkg::*;

  logic  clr_in;
  addr_t rob_to_if_newPC;
  addr_t if_to_mc_PC;
  logic  if_to_mc_ready;
  logic  mc_to_if_valid;
  data_t mc_to_if_inst;
  logic  mc_to_if_ready;
  logic  dec_to_if_full;
  logic  if_to_dec_valid;
  data_t if_to_dec_inst;
  addr_t if_to_dec_PC;

  // fetch unit side
  modport master (
    input  clr_in, rob_to_if_newPC, mc_to_if_valid, mc_to_if_inst,
           mc_to_if_ready, dec_to_if_full,
    output if_to_mc_PC, if_to_mc_ready, if_to_dec_valid, if_to_dec_inst,
           if_to_dec_PC
  );

  // surrounding pipeline side (ROB, memory controller, decoder)
  modport slave (
    output clr_in, rob_to_if_newPC, mc_to_if_valid, mc_to_if_inst,
           mc_to_if_ready, dec_to_if_full,
    input  if_to_mc_PC, if_to_mc_ready, if_to_dec_valid, if_to_dec_inst,
           if_to_dec_PC
  );
endinterface

// File: rtl/inst_fetch_cache_icache_array.sv
// Direct-mapped line storage: combinational read, synchronous write.
module inst_fetch_cache_icache_array
  import inst_fetch_cache_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output data_t            rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  data_t            wr_data
);
  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  data_t            data_q [LINES];

  // valid bits are the only storage that needs clearing on reset
  always_ff @(posedge clk_in) begin
    if (rst_in)     valid_q         <= '0;
    else if (wr_en) valid_q[wr_idx] <= 1'b1;
  end

  // tag and data are only meaningful behind a set valid bit
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];
endmodule

// File: rtl/inst_fetch_cache.sv
// Instruction fetch front end: PC, direct-mapped I-cache lookup, miss refill.
module inst_fetch_cache
  import inst_fetch_cache_pkg::*;
#(
  parameter int    IDX_W    = 6,
  parameter addr_t RESET_PC = 32'h0
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  inst_fetch_cache_if.master  bus
);
  localparam int TAG_W = 30 - IDX_W;

  if_state_e        state_q, state_d;
  addr_t            pc_q, pc_d;
  logic             emit, fill, hit;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag, rd_tag;
  logic             rd_valid;
  data_t            rd_data;
  logic             dec_valid_q;
  data_t            dec_inst_q;
  addr_t            dec_pc_q, mc_pc_q;

  assign idx = pc_q[IDX_W+1:2];
  assign tag = pc_q[31:IDX_W+2];
  assign hit = rd_valid && (rd_tag == tag);

  inst_fetch_cache_icache_array #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rd_idx  (idx),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (fill && rdy_in && !rst_in),
    .wr_idx  (idx),
    .wr_tag  (tag),
    .wr_data (bus.mc_to_if_inst)
  );

  // a request must never be accepted in a flush cycle, hence the clr gate
  assign bus.if_to_mc_ready  = (state_q == MISS_REQ) && !bus.clr_in;
  assign bus.if_to_mc_PC     = mc_pc_q;
  assign bus.if_to_dec_valid = dec_valid_q;
  assign bus.if_to_dec_inst  = dec_inst_q;
  assign bus.if_to_dec_PC    = dec_pc_q;

  // next state: redirect beats everything; a response during a flush is dropped
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    emit    = FALSE;
    fill    = FALSE;
    if (bus.clr_in) begin
      pc_d    = bus.rob_to_if_newPC;
      state_d = LOOKUP;
    end else begin
      case (state_q)
        LOOKUP: if (!bus.dec_to_if_full) begin
          if (hit) begin
            emit = TRUE;
            pc_d = pc_q + 32'd4;
          end else begin
            state_d = MISS_REQ;
          end
        end
        MISS_REQ:  if (bus.mc_to_if_valid) state_d = MISS_WAIT;
        MISS_WAIT: if (bus.mc_to_if_ready) begin
          fill    = TRUE;
          state_d = LOOKUP;
        end
        default: state_d = LOOKUP;
      endcase
    end
  end

  // state, PC and registered decoder/MC outputs; rdy_in low freezes all of it
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= LOOKUP;
      pc_q        <= RESET_PC;
      dec_valid_q <= FALSE;
      dec_inst_q  <= '0;
      dec_pc_q    <= '0;
      mc_pc_q     <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      dec_valid_q <= emit;
      if (emit) begin
        dec_inst_q <= rd_data;
        dec_pc_q   <= pc_q;
      end
      // PC is stable from here until the fill, so latch the fetch address once
      if (state_q == LOOKUP && state_d == MISS_REQ) mc_pc_q <= pc_q;
    end
  end
endmodule

// File: tb/tb_inst_fetch_cache.sv
// Bench: MC responder, program-order scoreboard and cache-content model.
module tb_inst_fetch_cache;
  import inst_fetch_cache_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in;
  inst_fetch_cache_if bus();

  inst_fetch_cache #(.IDX_W(6), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  int    vec_cnt = 0, err_cnt = 0;
  int    emit_cnt = 0, acc_cnt = 0, watch_cnt = 0, mcreq_cnt = 0;
  addr_t last_emit_pc = '1, watch_pc = 32'hFFFF_FFFF;
  addr_t exp_q[$];
  bit    model_v[64];
  addr_t model_a[64];
  bit    live_prev = 0;
  bit    mc_busy = 0, mc_avail = 1;
  int    mc_cnt = 0;
  addr_t mc_addr = '0;

  function automatic data_t mem_word(addr_t a);
    return (a * 32'h9E37_79B1) ^ 32'h13;
  endfunction

  function automatic bit model_hit(addr_t a);
    return model_v[a[7:2]] && model_a[a[7:2]] == a;
  endfunction

  function automatic void reload(addr_t p);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(p + addr_t'(4 * i));
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor and models: everything decided here applies at the coming edge
  always @(negedge clk_in) begin
    addr_t e;
    if (live_prev && bus.if_to_dec_valid === 1'b1) begin
      emit_cnt++;
      last_emit_pc = bus.if_to_dec_PC;
      e = exp_q.pop_front();
      check("emit_pc", bus.if_to_dec_PC, e);
      check("emit_inst", bus.if_to_dec_inst, mem_word(e));
      check("emit_from_cached_line", {31'b0, model_hit(e)}, 32'd1);
      while (exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd4);
    end
    if (bus.if_to_mc_ready === 1'b1) mcreq_cnt++;
    if (rst_in) begin
      mc_busy = 0;
      for (int i = 0; i < 64; i++) model_v[i] = 0;
      reload(32'h0);
    end else if (rdy_in) begin
      if (mc_busy && mc_cnt == 0) begin
        if (!bus.clr_in) begin
          model_v[mc_addr[7:2]] = 1;
          model_a[mc_addr[7:2]] = mc_addr;
        end
        mc_busy = 0;
      end else if (mc_busy && bus.clr_in) begin
        mc_busy = 0;
      end else if (mc_busy) begin
        mc_cnt--;
      end
      if (bus.if_to_mc_ready === 1'b1 && bus.mc_to_if_valid) begin
        acc_cnt++;
        if (bus.if_to_mc_PC == watch_pc) watch_cnt++;
        check("req_pc", bus.if_to_mc_PC, exp_q[0]);
        check("req_is_miss", {31'b0, model_hit(bus.if_to_mc_PC)}, 32'd0);
        mc_busy = 1;
        mc_addr = bus.if_to_mc_PC;
        mc_cnt  = 5;
      end
      if (bus.clr_in) reload(bus.rob_to_if_newPC);
    end
    live_prev = !rst_in && rdy_in;
  end

  // memory controller outputs follow the model state after each edge
  always @(posedge clk_in) begin
    #1;
    bus.mc_to_if_ready = mc_busy && mc_cnt == 0;
    bus.mc_to_if_inst  = (mc_busy && mc_cnt == 0) ? mem_word(mc_addr) : $urandom;
    bus.mc_to_if_valid = !mc_busy && mc_avail;
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk_in); #2; end
  endtask

  task automatic redirect(addr_t a);
    bus.clr_in = 1; bus.rob_to_if_newPC = a;
    tick(1);
    bus.clr_in = 0;
  endtask

  task automatic wait_emit_pc(addr_t a, int budget);
    int base = emit_cnt;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (emit_cnt != base && last_emit_pc == a) return;
      base = emit_cnt;
    end
    vec_cnt++; err_cnt++;
    $display("FAIL timeout_emit: got no emit expected pc %h", a);
  endtask

  task automatic wait_accept(int budget);
    int base = acc_cnt;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (acc_cnt != base) return;
    end
    vec_cnt++; err_cnt++;
    $display("FAIL timeout_accept: got no request accept expected one");
  endtask

  initial begin
    int e0, r0, w0, a0;
    rst_in = 1; rdy_in = 1;
    bus.clr_in = 0; bus.rob_to_if_newPC = '0; bus.dec_to_if_full = 0;
    tick(2);
    check("rst_dec_valid", {31'b0, bus.if_to_dec_valid}, 32'd0);
    check("rst_dec_inst", bus.if_to_dec_inst, 32'd0);
    check("rst_dec_pc", bus.if_to_dec_PC, 32'd0);
    check("rst_mc_pc", bus.if_to_mc_PC, 32'd0);
    check("rst_mc_ready", {31'b0, bus.if_to_mc_ready}, 32'd0);
    rst_in = 0;

    // cold start: PC 0 misses, refills, then 4 and 8 follow
    watch_pc = 32'h0; w0 = watch_cnt;
    wait_emit_pc(32'h0, 60);
    check("t1_req_for_pc0", watch_cnt - w0, 1);
    wait_emit_pc(32'h4, 60);
    wait_emit_pc(32'h8, 60);

    // loop back to 0: three back-to-back hits, no MC traffic
    e0 = emit_cnt; r0 = mcreq_cnt;
    redirect(32'h0);
    tick(4);
    check("t2_loop_emits", emit_cnt - e0, 3);
    check("t2_loop_no_req", mcreq_cnt - r0, 0);
    check("t2_loop_last_pc", last_emit_pc, 32'h8);

    // aliasing on index 0
    watch_pc = 32'h100; w0 = watch_cnt;
    redirect(32'h100);
    wait_emit_pc(32'h100, 60);
    check("t3_alias_miss", watch_cnt - w0, 1);
    watch_pc = 32'h0; w0 = watch_cnt;
    redirect(32'h0);
    wait_emit_pc(32'h0, 60);
    check("t3_evicted_miss", watch_cnt - w0, 1);

    // flush two cycles after acceptance
    redirect(32'h200);
    wait_accept(40);
    tick(1);
    watch_pc = 32'h40; w0 = watch_cnt;
    redirect(32'h40);
    wait_emit_pc(32'h40, 60);
    check("t4_req_after_flush", watch_cnt - w0, 1);

    // flush coinciding with the response: data dropped, refetched
    watch_pc = 32'h300; w0 = watch_cnt;
    redirect(32'h300);
    wait_accept(40);
    tick(5);
    redirect(32'h300);
    wait_emit_pc(32'h300, 60);
    check("t4_late_resp_dropped", watch_cnt - w0, 2);

    // backpressure on a hit
    bus.dec_to_if_full = 1;
    e0 = emit_cnt; r0 = mcreq_cnt;
    redirect(32'h300);
    tick(5);
    check("t5_full_no_emit", emit_cnt - e0, 0);
    check("t5_full_no_req", mcreq_cnt - r0, 0);
    bus.dec_to_if_full = 0;
    tick(2);
    check("t5_release_one_emit", emit_cnt - e0, 1);
    check("t5_release_pc", last_emit_pc, 32'h300);

    // controller busy, then global stall, then acceptance
    mc_avail = 0;
    redirect(32'h800);
    tick(2);
    for (int i = 0; i < 4; i++) begin
      check("t6_req_held", {31'b0, bus.if_to_mc_ready}, 32'd1);
      check("t6_req_pc", bus.if_to_mc_PC, 32'h800);
      tick(1);
    end
    rdy_in = 0; mc_avail = 1; a0 = acc_cnt;
    tick(3);
    check("t6_frozen_no_accept", acc_cnt - a0, 0);
    check("t6_frozen_req", {31'b0, bus.if_to_mc_ready}, 32'd1);
    check("t6_frozen_pc", bus.if_to_mc_PC, 32'h800);
    check("t6_frozen_dec_valid", {31'b0, bus.if_to_dec_valid}, 32'd0);
    rdy_in = 1;
    tick(1);
    check("t6_accept_first", acc_cnt - a0, 1);
    wait_emit_pc(32'h800, 60);

    // randomized traffic, checked entirely by the monitor
    e0 = emit_cnt;
    for (int i = 0; i < 3000; i++) begin
      bus.dec_to_if_full = ($urandom % 4) == 0;
      mc_avail = ($urandom % 3) != 0;
      rdy_in = ($urandom % 10) != 0;
      if (($urandom % 40) == 0) begin
        bus.clr_in = 1;
        if (($urandom % 5) == 0) bus.rob_to_if_newPC = 32'hFFFF_FFF0;
        else bus.rob_to_if_newPC = addr_t'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2));
      end else begin
        bus.clr_in = 0;
      end
      tick(1);
    end
    bus.clr_in = 0; bus.dec_to_if_full = 0; rdy_in = 1; mc_avail = 1;
    tick(20);
    check("rand_progress", {31'b0, (emit_cnt - e0) > 100}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
